grf_wb_arbiter: RTL and testbench

//  Write-side front end of the general register file. It merges two result

---
 rtl/grf_wb_arbiter_if.sv | 27 ++
 rtl/grf_wb_arbiter.sv | 61 ++++++
 tb/tb_grf_wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: pipe/MDU producer inputs, GRF write port and hazard query of the write-side arbiter
interface grf_wb_arbiter_if #(parameter int AW = 2);
  logic          pipe_we;
  logic [4:0]    pipe_a3;
  logic [31:0]   pipe_wd;
  logic [31:0]   pipe_pc;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_a3;
  logic [31:0]   mdu_wd;
  logic [31:0]   mdu_pc;
  logic          grf_we;
  logic [4:0]    grf_a3;
  logic [31:0]   grf_wd;
  logic [31:0]   grf_pc;
  logic [AW:0]   q_count;
  logic [4:0]    qry_a;
  logic          qry_hit;
  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc, qry_a,
    input  mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, q_count, qry_hit
  );
  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc, mdu_valid, mdu_a3, mdu_wd, mdu_pc, qry_a,
    output mdu_ready, grf_we, grf_a3, grf_wd, grf_pc, q_count, qry_hit
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges W-stage writes and a FIFO-buffered MDU result stream onto the GRF write port
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic clk,
  input logic reset,
  grf_wb_arbiter_if.slave bus
);
  logic [4:0]    q_a3 [DEPTH];
  logic [31:0]   q_wd [DEPTH];
  logic [31:0]   q_pc [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          pipe_sel, push, enq, pop, hit;
  assign pipe_sel = bus.pipe_we && bus.pipe_a3 != 5'd0;
  assign bus.mdu_ready = !reset && count != (AW+1)'(DEPTH);
  assign push = bus.mdu_valid && bus.mdu_ready;
  assign enq = push && bus.mdu_a3 != 5'd0;
  assign pop = !pipe_sel && count != '0;
  assign bus.q_count = count;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (live[i] && q_a3[i] == bus.qry_a);
    bus.qry_hit = bus.qry_a != 5'd0 && hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      live <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      bus.grf_we <= 1'b0;
      bus.grf_a3 <= '0;
      bus.grf_wd <= '0;
      bus.grf_pc <= '0;
    end else begin
      // a pipeline write is newer than anything queued for the same register
      for (int i = 0; i < DEPTH; i++)
        if (pipe_sel && q_a3[i] == bus.pipe_a3) live[i] <= 1'b0;
      if (pop) begin
        live[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (enq) begin
        q_a3[tail] <= bus.mdu_a3;
        q_wd[tail] <= bus.mdu_wd;
        q_pc[tail] <= bus.mdu_pc;
        live[tail] <= !(pipe_sel && bus.mdu_a3 == bus.pipe_a3);
        tail <= tail + 1'b1;
      end
      count <= count + (AW+1)'(enq) - (AW+1)'(pop);
      bus.grf_we <= pipe_sel || (pop && live[head]);
      bus.grf_a3 <= pipe_sel ? bus.pipe_a3 : (pop && live[head]) ? q_a3[head] : 5'd0;
      bus.grf_wd <= pipe_sel ? bus.pipe_wd : (pop && live[head]) ? q_wd[head] : 32'd0;
      bus.grf_pc <= pipe_sel ? bus.pipe_pc : (pop && live[head]) ? q_pc[head] : 32'd0;
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed checks of pipe priority, MDU FIFO ordering, WAW kill and reset flush
module tb_grf_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  grf_wb_arbiter_if #(.AW(2)) bus ();
  grf_wb_arbiter #(.DEPTH(4), .AW(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic grf(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd);
    chk({tag, "_we"}, 32'(bus.grf_we), 32'(we));
    chk({tag, "_a3"}, 32'(bus.grf_a3), 32'(a3));
    chk({tag, "_wd"}, bus.grf_wd, wd);
  endtask
  initial begin
    bus.pipe_we = 0; bus.pipe_a3 = 0; bus.pipe_wd = 0; bus.pipe_pc = 0;
    bus.mdu_valid = 0; bus.mdu_a3 = 0; bus.mdu_wd = 0; bus.mdu_pc = 0; bus.qry_a = 0;
    step(); step();
    chk("rst_ready", 32'(bus.mdu_ready), 0);
    chk("rst_count", 32'(bus.q_count), 0);
    grf("rst", 0, 0, 0);
    chk("rst_pc", bus.grf_pc, 0);
    reset = 0;
    #1;
    chk("ready_after_rst", 32'(bus.mdu_ready), 1);
    // T1 pipe write
    bus.pipe_we = 1; bus.pipe_a3 = 5; bus.pipe_wd = 32'h1234; bus.pipe_pc = 32'h100;
    step();
    grf("t1", 1, 5, 32'h1234);
    chk("t1_pc", bus.grf_pc, 32'h100);
    bus.pipe_we = 0;
    // T2 single MDU result, two-cycle latency
    bus.mdu_valid = 1; bus.mdu_a3 = 8; bus.mdu_wd = 32'hAA; bus.mdu_pc = 32'h200;
    step();
    bus.mdu_valid = 0;
    chk("t2_count1", 32'(bus.q_count), 1);
    chk("t2_we_idle", 32'(bus.grf_we), 0);
    bus.qry_a = 8;
    #1;
    chk("t2_qry", 32'(bus.qry_hit), 1);
    step();
    grf("t2", 1, 8, 32'hAA);
    chk("t2_pc", bus.grf_pc, 32'h200);
    chk("t2_count0", 32'(bus.q_count), 0);
    chk("t2_qry0", 32'(bus.qry_hit), 0);
    // T3 fill while pipe busy, then drain in order
    bus.pipe_we = 1; bus.pipe_a3 = 1;
    bus.mdu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.mdu_a3 = 5'(10 + i); bus.mdu_wd = 32'(16'hB0 + i); bus.pipe_wd = 32'(i);
      step();
      grf("t3_pipe", 1, 1, 32'(i));
    end
    bus.mdu_valid = 0;
    chk("t3_full", 32'(bus.q_count), 4);
    chk("t3_ready0", 32'(bus.mdu_ready), 0);
    bus.qry_a = 12;
    #1;
    chk("t3_qry12", 32'(bus.qry_hit), 1);
    bus.pipe_we = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      grf("t3_drain", 1, 5'(10 + i), 32'(16'hB0 + i));
      chk("t3_cnt", 32'(bus.q_count), 32'(3 - i));
    end
    // T4 pipe write kills queued entry for same register
    bus.mdu_valid = 1; bus.mdu_a3 = 9; bus.mdu_wd = 32'h11;
    step();
    bus.mdu_valid = 0;
    bus.pipe_we = 1; bus.pipe_a3 = 9; bus.pipe_wd = 32'h55;
    bus.qry_a = 9;
    #1;
    chk("t4_qry_before", 32'(bus.qry_hit), 1);
    step();
    bus.pipe_we = 0;
    grf("t4_pipe", 1, 9, 32'h55);
    chk("t4_qry_after", 32'(bus.qry_hit), 0);
    step();
    grf("t4_drain", 0, 0, 0);
    chk("t4_cnt", 32'(bus.q_count), 0);
    // T5 MDU push to r0 is accepted but dropped
    bus.mdu_valid = 1; bus.mdu_a3 = 0; bus.mdu_wd = 32'h77;
    #1;
    chk("t5_ready", 32'(bus.mdu_ready), 1);
    step();
    bus.mdu_valid = 0;
    chk("t5_cnt", 32'(bus.q_count), 0);
    step();
    chk("t5_we", 32'(bus.grf_we), 0);
    // T7 same-cycle push and pipe write to same register stores killed entry
    bus.pipe_we = 1; bus.pipe_a3 = 7; bus.pipe_wd = 32'h70;
    bus.mdu_valid = 1; bus.mdu_a3 = 7; bus.mdu_wd = 32'h71;
    bus.qry_a = 7;
    step();
    bus.pipe_we = 0; bus.mdu_valid = 0;
    grf("t7_pipe", 1, 7, 32'h70);
    chk("t7_cnt", 32'(bus.q_count), 1);
    chk("t7_qry", 32'(bus.qry_hit), 0);
    step();
    grf("t7_drain", 0, 0, 0);
    chk("t7_cnt0", 32'(bus.q_count), 0);
    // T6 reset flushes a partially full queue
    bus.pipe_we = 1; bus.pipe_a3 = 1; bus.mdu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.mdu_a3 = 5'(20 + i);
      step();
    end
    bus.pipe_we = 0; bus.mdu_valid = 0;
    chk("t6_cnt3", 32'(bus.q_count), 3);
    reset = 1;
    step();
    chk("t6_cnt0", 32'(bus.q_count), 0);
    chk("t6_we", 32'(bus.grf_we), 0);
    chk("t6_ready0", 32'(bus.mdu_ready), 0);
    reset = 0;
    bus.qry_a = 21;
    #1;
    chk("t6_ready1", 32'(bus.mdu_ready), 1);
    chk("t6_qry", 32'(bus.qry_hit), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_nowrite", 32'(bus.grf_we), 0);
      chk("t6_cnt", 32'(bus.q_count), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
